// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0).
//
// Bytes arrive on a valid/ready stream and are shifted out MSB first while the
// byte returning on miso is assembled in parallel. Each completed byte is
// presented on rx_data with a one-cycle rx_valid pulse. tx_last closes the
// frame: chip_enable is released after a hold time and kept high for a minimum
// deselect gap. Without tx_last the master parks in a mid-frame wait with
// chip_enable low and sclk low until the next byte arrives.
//
// Parameters:
//   CLK_DIV     clk cycles per SCLK half-period, legal range 1..255.
// Ports:
//   clk         system clock, rising edge.
//   rst_n       asynchronous active-low reset; aborts any transfer.
//   tx_data     byte to send, sampled only at accept.
//   tx_last     frame-end flag for tx_data, sampled only at accept.
//   tx_valid    tx_data/tx_last valid.
//   tx_ready    byte accepted when tx_valid && tx_ready.
//   rx_data     last byte received; held until the next rx_valid.
//   rx_valid    one-cycle pulse, rx_data valid.
//   busy        high whenever the FSM is not idle.
//   sclk        SPI clock, idles low.
//   mosi        master out, MSB first.
//   miso        slave in, already synchronous to clk.
//   chip_enable active-low slave select.
// All outputs are registered.

module spi_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       chip_enable
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShiftHi,
        StShiftLo,
        StWait,
        StHold,
        StGap
    } state_e;

    localparam logic [7:0] CntMax = 8'(CLK_DIV - 1);

    // State and datapath registers
    state_e     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_shift;
    logic       r_last;

    // Registered outputs
    logic       r_tx_ready;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_busy;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_ce;

    // Next-state values
    state_e     w_state_d;
    logic [7:0] w_cnt_d;
    logic [2:0] w_bit_d;
    logic [7:0] w_tx_shift_d;
    logic [7:0] w_rx_shift_d;
    logic       w_last_d;
    logic       w_tx_ready_d;
    logic [7:0] w_rx_data_d;
    logic       w_rx_valid_d;
    logic       w_sclk_d;
    logic       w_mosi_d;
    logic       w_ce_d;

    logic       w_accept;
    logic       w_cnt_done;
    logic       w_load;

    assign w_accept   = tx_valid & r_tx_ready;
    assign w_cnt_done = (r_cnt == CntMax);

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_bit_d      = r_bit;
        w_tx_shift_d = r_tx_shift;
        w_rx_shift_d = r_rx_shift;
        w_last_d     = r_last;
        w_tx_ready_d = 1'b0;
        w_rx_data_d  = r_rx_data;
        w_rx_valid_d = 1'b0;
        w_sclk_d     = r_sclk;
        w_mosi_d     = r_mosi;
        w_ce_d       = r_ce;
        w_load       = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_load = 1'b1;
                end else begin
                    w_tx_ready_d = 1'b1;
                end
            end

            StSetup: begin
                if (w_cnt_done) begin
                    w_cnt_d      = 8'd0;
                    w_sclk_d     = 1'b1;
                    w_rx_shift_d = {r_rx_shift[6:0], miso};
                    w_state_d    = StShiftHi;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end

            StShiftHi: begin
                if (w_cnt_done) begin
                    w_cnt_d  = 8'd0;
                    w_sclk_d = 1'b0;
                    if (r_bit != 3'd0) begin
                        w_bit_d      = r_bit - 3'd1;
                        w_tx_shift_d = {r_tx_shift[6:0], 1'b0};
                        w_mosi_d     = r_tx_shift[6];
                        w_state_d    = StShiftLo;
                    end else begin
                        // Last falling edge: byte complete. tx_ready stays low
                        // in this cycle so an accept never meets rx_valid.
                        w_rx_data_d  = r_rx_shift;
                        w_rx_valid_d = 1'b1;
                        w_state_d    = r_last ? StHold : StWait;
                    end
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end

            StShiftLo: begin
                if (w_cnt_done) begin
                    w_cnt_d      = 8'd0;
                    w_sclk_d     = 1'b1;
                    w_rx_shift_d = {r_rx_shift[6:0], miso};
                    w_state_d    = StShiftHi;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end

            StWait: begin
                // Mid-frame stall: select stays asserted, sclk parked low.
                if (w_accept) begin
                    w_load = 1'b1;
                end else begin
                    w_tx_ready_d = 1'b1;
                end
            end

            StHold: begin
                if (w_cnt_done) begin
                    w_cnt_d   = 8'd0;
                    w_ce_d    = 1'b1;
                    w_mosi_d  = 1'b0;
                    w_state_d = StGap;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end

            StGap: begin
                if (w_cnt_done) begin
                    w_cnt_d      = 8'd0;
                    w_tx_ready_d = 1'b1;
                    w_state_d    = StIdle;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end

            default: begin
                w_cnt_d   = 8'd0;
                w_sclk_d  = 1'b0;
                w_ce_d    = 1'b1;
                w_mosi_d  = 1'b0;
                w_state_d = StIdle;
            end
        endcase

        // Byte load shared by the idle and mid-frame wait states.
        if (w_load) begin
            w_tx_shift_d = tx_data;
            w_last_d     = tx_last;
            w_mosi_d     = tx_data[7];
            w_ce_d       = 1'b0;
            w_bit_d      = 3'd7;
            w_cnt_d      = 8'd0;
            w_state_d    = StSetup;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= 8'd0;
            r_bit      <= 3'd0;
            r_tx_shift <= 8'd0;
            r_rx_shift <= 8'd0;
            r_last     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ce       <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_bit      <= w_bit_d;
            r_tx_shift <= w_tx_shift_d;
            r_rx_shift <= w_rx_shift_d;
            r_last     <= w_last_d;
            r_tx_ready <= w_tx_ready_d;
            r_rx_data  <= w_rx_data_d;
            r_rx_valid <= w_rx_valid_d;
            r_busy     <= (w_state_d != StIdle);
            r_sclk     <= w_sclk_d;
            r_mosi     <= w_mosi_d;
            r_ce       <= w_ce_d;
        end
    end

    assign tx_ready    = r_tx_ready;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign busy        = r_busy;
    assign sclk        = r_sclk;
    assign mosi        = r_mosi;
    assign chip_enable = r_ce;

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps

module tb_spi_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT a: CLK_DIV=2, DUT b: CLK_DIV=1
    logic [7:0] tx_data_a, rx_data_a, tx_data_b, rx_data_b;
    logic tx_last_a, tx_valid_a, tx_ready_a, rx_valid_a, busy_a, sclk_a, mosi_a, miso_a, ce_a;
    logic tx_last_b, tx_valid_b, tx_ready_b, rx_valid_b, busy_b, sclk_b, mosi_b, miso_b, ce_b;
    logic loop_a, loop_b, miso_k_a, miso_k_b;

    assign miso_a = loop_a ? mosi_a : miso_k_a;
    assign miso_b = loop_b ? mosi_b : miso_k_b;

    spi_master #(.CLK_DIV(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_last(tx_last_a),
        .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
        .rx_valid(rx_valid_a), .busy(busy_a), .sclk(sclk_a), .mosi(mosi_a),
        .miso(miso_a), .chip_enable(ce_a)
    );

    spi_master #(.CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_last(tx_last_b),
        .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
        .rx_valid(rx_valid_b), .busy(busy_b), .sclk(sclk_b), .mosi(mosi_b),
        .miso(miso_b), .chip_enable(ce_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitors, sampled just after each rising edge.
    int rise_a = 0, rise_b = 0, ce_rise_a = 0, ce_rise_b = 0, rxv_a = 0, viol = 0;
    int ce_rise_cyc_a = -1, ce_rise_cyc_b = -1;
    logic [31:0] mosi_h_a = 0, mosi_h_b = 0;
    logic sclk_pa = 0, sclk_pb = 0, ce_pa = 1, ce_pb = 1;

    always @(posedge clk) begin
        #1;
        if (sclk_a && !sclk_pa) begin
            rise_a++;
            mosi_h_a = {mosi_h_a[30:0], mosi_a};
        end
        if (sclk_b && !sclk_pb) begin
            rise_b++;
            mosi_h_b = {mosi_h_b[30:0], mosi_b};
        end
        if (ce_a && !ce_pa) begin
            ce_rise_a++;
            ce_rise_cyc_a = cyc;
        end
        if (ce_b && !ce_pb) begin
            ce_rise_b++;
            ce_rise_cyc_b = cyc;
        end
        if (rx_valid_a) rxv_a++;
        if ((sclk_a && ce_a) || (sclk_b && ce_b)) viol++;
        sclk_pa = sclk_a;
        sclk_pb = sclk_b;
        ce_pa   = ce_a;
        ce_pb   = ce_b;
    end

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for tx_ready, presents one byte for one cycle. t = accept cycle.
    task automatic send(input bit sel, input logic [7:0] d, input bit last,
                        output int t, output bit ok);
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ((sel ? tx_ready_b : tx_ready_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            if (sel) begin
                tx_data_b = d; tx_last_b = last; tx_valid_b = 1'b1;
            end else begin
                tx_data_a = d; tx_last_a = last; tx_valid_a = 1'b1;
            end
            t = cyc;
            @(negedge clk);
            tx_valid_a = 1'b0;
            tx_valid_b = 1'b0;
        end
    endtask

    task automatic wait_rx(input bit sel, output bit ok, output int c, output logic [7:0] d);
        ok = 1'b0;
        c  = -1;
        d  = 8'hxx;
        for (int i = 0; i < 2000; i++) begin
            if ((sel ? rx_valid_b : rx_valid_a) === 1'b1) begin
                ok = 1'b1;
                c  = cyc;
                d  = sel ? rx_data_b : rx_data_a;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(input bit sel, output int c);
        c = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ((sel ? tx_ready_b : tx_ready_a) === 1'b1) begin
                c = cyc;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c, base, base2, bad;
        bit ok;
        logic [7:0] d;
        logic [7:0] frame [3];

        rst_n = 1'b0;
        tx_data_a = 8'h00; tx_last_a = 1'b0; tx_valid_a = 1'b1;
        tx_data_b = 8'h00; tx_last_b = 1'b0; tx_valid_b = 1'b0;
        loop_a = 1'b1; loop_b = 1'b1; miso_k_a = 1'b0; miso_k_b = 1'b0;

        // 1. Reset with tx_valid asserted
        repeat (3) @(negedge clk);
        check("rst_ce", {31'd0, ce_a}, 32'd1);
        check("rst_sclk", {31'd0, sclk_a}, 32'd0);
        check("rst_mosi", {31'd0, mosi_a}, 32'd0);
        check("rst_ready", {31'd0, tx_ready_a}, 32'd0);
        check("rst_rxv", {31'd0, rx_valid_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_rxdata", {24'd0, rx_data_a}, 32'd0);
        rst_n = 1'b1;
        tx_valid_a = 1'b0;
        @(negedge clk);
        check("rel_ready", {31'd0, tx_ready_a}, 32'd1);

        // 2. Single byte 0xA5, loopback, CLK_DIV=2
        base = rise_a;
        send(1'b0, 8'hA5, 1'b1, t, ok);
        check("t2_accept", {31'd0, ok}, 32'd1);
        check("t2_ce_low", {31'd0, ce_a}, 32'd0);
        wait_rx(1'b0, ok, c, d);
        check("t2_rx_seen", {31'd0, ok}, 32'd1);
        check("t2_rx_cyc", c, t + 33);
        check("t2_rx_data", {24'd0, d}, 32'h0000_00A5);
        wait_ready(1'b0, c);
        check("t2_rises", rise_a - base, 32'd8);
        check("t2_mosi_bits", {24'd0, mosi_h_a[7:0]}, 32'h0000_00A5);
        check("t2_ce_rise_cyc", ce_rise_cyc_a, t + 35);
        check("t2_ready_cyc", c, t + 37);
        check("t2_rx_hold", {24'd0, rx_data_a}, 32'h0000_00A5);

        // 3. Three-byte frame, miso constant 1
        loop_a = 1'b0; miso_k_a = 1'b1;
        frame[0] = 8'h01; frame[1] = 8'h80; frame[2] = 8'hFF;
        base  = rise_a;
        base2 = ce_rise_a;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, frame[i], i == 2, t, ok);
            check("t3_accept", {31'd0, ok}, 32'd1);
            wait_rx(1'b0, ok, c, d);
            check("t3_rx_cyc", c, t + 33);
            check("t3_rx_data", {24'd0, d}, 32'h0000_00FF);
            if (i < 2) check("t3_ce_mid", ce_rise_a - base2, 32'd0);
        end
        wait_ready(1'b0, c);
        check("t3_rises", rise_a - base, 32'd24);
        check("t3_mosi_bits", mosi_h_a[23:0], 32'h0001_80FF);
        check("t3_ce_rises", ce_rise_a - base2, 32'd1);

        // 4. Mid-frame stall of 100 cycles
        loop_a = 1'b1;
        send(1'b0, 8'h3C, 1'b0, t, ok);
        wait_rx(1'b0, ok, c, d);
        check("t4_rx0", {24'd0, d}, 32'h0000_003C);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!(ce_a === 1'b0 && sclk_a === 1'b0 && tx_ready_a === 1'b1)) bad++;
        end
        check("t4_stall_bad", bad, 32'd0);
        send(1'b0, 8'hC3, 1'b1, t, ok);
        wait_rx(1'b0, ok, c, d);
        check("t4_rx1_cyc", c, t + 33);
        check("t4_rx1", {24'd0, d}, 32'h0000_00C3);
        wait_ready(1'b0, c);

        // 5. Reset after the fourth sclk rise
        base  = rise_a;
        base2 = rxv_a;
        send(1'b0, 8'hE7, 1'b1, t, ok);
        for (int i = 0; i < 200; i++) begin
            if (rise_a - base >= 4) break;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("t5_ce", {31'd0, ce_a}, 32'd1);
        check("t5_sclk", {31'd0, sclk_a}, 32'd0);
        check("t5_busy", {31'd0, busy_a}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_no_rxv", rxv_a - base2, 32'd0);
        send(1'b0, 8'h5A, 1'b1, t, ok);
        wait_rx(1'b0, ok, c, d);
        check("t5_rx_cyc", c, t + 33);
        check("t5_rx_data", {24'd0, d}, 32'h0000_005A);
        wait_ready(1'b0, c);

        // 6. CLK_DIV=1, loopback 0xF0
        base = rise_b;
        send(1'b1, 8'hF0, 1'b1, t, ok);
        check("t6_accept", {31'd0, ok}, 32'd1);
        wait_rx(1'b1, ok, c, d);
        check("t6_rx_cyc", c, t + 17);
        check("t6_rx_data", {24'd0, d}, 32'h0000_00F0);
        wait_ready(1'b1, c);
        check("t6_rises", rise_b - base, 32'd8);
        check("t6_mosi_bits", {24'd0, mosi_h_b[7:0]}, 32'h0000_00F0);
        check("t6_ce_rise_cyc", ce_rise_cyc_b, t + 18);
        check("t6_ready_cyc", c, t + 19);

        check("sclk_while_deselected", viol, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master; drives the opposite end of the bus from spi_slave (sclk, mosi, miso, active-low chip_enable).
- Accepts bytes over a valid/ready stream and shifts them out MSB first.
- Returns each full-duplex received byte as a one-cycle pulse.
- Used by the miner controller and by spi_slave benches to push job data and read results.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- tx_data  input  8  byte to send.
- tx_last  input  1  qualifies tx_data; 1 means this byte ends the frame.
- tx_valid  input  1  tx_data/tx_last valid.
- tx_ready  output  1  byte accepted when tx_valid && tx_ready.
- rx_data  output  8  byte received during the last completed byte.
- rx_valid  output  1  one-cycle pulse; rx_data valid.
- busy  output  1  high whenever state != IDLE.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  master out, MSB first.
- miso  input  1  slave out; synchronous to clk, no synchronizer.
- chip_enable  output  1  active-low select; 1 = deselected.

Behaviour:
- Reset values while rst_n=0: chip_enable=1, sclk=0, mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, state=IDLE, counters cleared.
- Assertion mid-transfer aborts immediately; no rx_valid is produced. First cycle after release: tx_ready=1.
- All outputs are registered.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, WAIT, HOLD, GAP. A half-period counter counts 0..CLK_DIV-1; a bit counter counts 7..0.
- IDLE: tx_ready=1. On accept:
  - latch tx_data into the shift register and tx_last into the frame-end flag;
  - next cycle chip_enable=0 and mosi=bit7;
  - go to SETUP.
- SETUP: hold for CLK_DIV cycles, then drive sclk=1, sample miso into rx shift LSB on that same clk edge, and go to SHIFT_HI.
- SHIFT_HI: after CLK_DIV cycles, sclk=0.
  - If bits remain: mosi = next bit on that same edge, go to SHIFT_LO.
  - If bit 0 is done: rx_data = assembled byte, rx_valid=1 for exactly this one cycle. Go to HOLD if the frame-end flag is set, else WAIT.
- SHIFT_LO: after CLK_DIV cycles, sclk=1, sample miso, go to SHIFT_HI.
- Timing: accept at cycle T gives chip_enable low at T+1, first sclk rise at T+1+CLK_DIV, rx_valid at T+1+16*CLK_DIV. With CLK_DIV=2, rx_valid is at T+33.
- WAIT (mid-frame): chip_enable stays 0, sclk stays 0, tx_ready=1. The master may stall indefinitely.
  - On accept: load the byte, mosi=bit7 next cycle, go to SETUP (CLK_DIV setup before first rise).
  - tx_ready is 0 in the rx_valid cycle, so an accept can never coincide with rx_valid.
- HOLD: chip_enable held 0 for CLK_DIV cycles after the last falling edge, then chip_enable=1, mosi=0, go to GAP.
- GAP: chip_enable=1 for CLK_DIV cycles minimum deselect time, tx_ready=0, then IDLE.
- tx_valid low in IDLE means no activity, chip_enable stays 1.
- tx_data and tx_last are ignored except at accept.
- A single-byte frame (tx_last=1 on the first byte) is legal.
- sclk is never high while chip_enable=1.
- No sclk edge occurs within CLK_DIV cycles of a chip_enable transition.
- rx_data holds its value until the next rx_valid.

Test Plan:
1. Reset: hold rst_n=0 while tx_valid=1 -> chip_enable=1, sclk=0, mosi=0, tx_ready=0, rx_valid=0. Release -> tx_ready=1 next cycle.
2. Single byte, CLK_DIV=2, miso tied to mosi: send 0xA5 with tx_last=1 -> mosi bits observed at sclk rises are 1,0,1,0,0,1,0,1; exactly 8 rises; rx_valid at T+33 with rx_data=0xA5; chip_enable rises at T+35; tx_ready returns at T+37.
3. Three-byte frame 0x01, 0x80, 0xFF with last on 0xFF and miso=1 constant -> chip_enable stays low through all 24 sclk rises; three rx_valid pulses each with rx_data=0xFF; one chip_enable rise after the third byte.
4. Stall: first byte 0x3C with tx_last=0, tx_valid withheld 100 cycles -> chip_enable stays 0, sclk stays 0, tx_ready=1 throughout. Send 0xC3 with last=1 -> completes normally, rx sequence correct.
5. Reset mid-byte: assert rst_n=0 after the 4th sclk rise -> the same cycle gives chip_enable=1, sclk=0; no rx_valid. The next transfer of 0x5A completes correctly.
6. CLK_DIV=1, loopback, send 0xF0 with last=1 -> sclk toggles every clk cycle; rx_valid at T+17 with rx_data=0xF0.
